// File: rtl/spi_sensor_mean_mc.sv
// Round-robin SPI temperature sensor reader: averages 2^SamplesLog2 frames per channel and interrupts on change.
// Optional feature: define SPI_SENSOR_MEAN_MC_IRQ_CHANNEL_EN to add the IntrChannel_o port.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_DISABLED | stopped, chip selects high, round state cleared
// S_IDLE     | waiting for the period counter to expire
// S_WRITE    | two TX bytes (0x00) pushed to the SPI master, CS low
// S_WAIT     | waiting for the transfer to finish and RX data to arrive
// S_READ1    | pop MSB from RX FIFO
// S_READ2    | pop LSB, accumulate sample
// S_PAUSE    | gap between samples of the same channel
// S_EVAL     | compare mean with last reported value, maybe interrupt
module spi_sensor_mean_mc #(
    parameter int Channels    = 2,
    parameter int SamplesLog2 = 2
) (
    input  logic                    Clk_i,
    input  logic                    Reset_n_i,
    input  logic                    Enable_i,
    output logic [Channels-1:0]     CS_n_o,
    output logic                    CpuIntr_o,
    output logic [7:0]              SPI_Data_o,
    output logic                    SPI_Write_o,
    output logic                    SPI_ReadNext_o,
    input  logic [7:0]              SPI_Data_i,
    input  logic                    SPI_FIFOEmpty_i,
    input  logic                    SPI_FIFOFull_i,
    input  logic                    SPI_Transmission_i,
    input  logic [15:0]             PeriodCounterPresetH_i,
    input  logic [15:0]             PeriodCounterPresetL_i,
    input  logic [15:0]             PauseCounterPreset_i,
    input  logic [15:0]             Threshold_i,
`ifdef SPI_SENSOR_MEAN_MC_IRQ_CHANNEL_EN
    output logic [1:0]              IntrChannel_o,
`endif
    output logic [16*Channels-1:0]  SensorValue_o
);

    localparam int CHW  = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int SCW  = (SamplesLog2 > 0) ? SamplesLog2 : 1;
    localparam int ACCW = 16 + SamplesLog2;
    localparam logic [CHW-1:0] LAST_CH     = CHW'(Channels - 1);
    localparam logic [SCW-1:0] LAST_SAMPLE = SCW'((1 << SamplesLog2) - 1);

    typedef enum logic [2:0] {
        S_DISABLED,
        S_IDLE,
        S_WRITE,
        S_WAIT,
        S_READ1,
        S_READ2,
        S_PAUSE,
        S_EVAL
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [31:0]        r_period_cnt;
    logic [15:0]        r_pause_cnt;
    logic               r_write_cnt;
    logic [SCW-1:0]     r_sample_cnt;
    logic [CHW-1:0]     r_ch;
    logic [7:0]         r_msb;
    logic [ACCW-1:0]    r_acc;
    logic [15:0]        r_sensor_value [Channels];
    logic               r_cpu_intr;

    logic               w_period_zero;
    logic               w_last_sample;
    logic               w_last_ch;
    logic [15:0]        w_mean;
    logic [15:0]        w_sv_cur;
    logic [16:0]        w_diff;
    logic               w_report;
    logic [Channels-1:0] w_cs_n;
    logic               w_unused;

    // TX FIFO full is never acted on: a frame is only two bytes.
    assign w_unused      = SPI_FIFOFull_i;

    assign w_period_zero = (r_period_cnt == 32'd0);
    assign w_last_sample = (r_sample_cnt == LAST_SAMPLE);
    assign w_last_ch     = (r_ch == LAST_CH);
    assign w_mean        = 16'(r_acc >> SamplesLog2);
    assign w_sv_cur      = r_sensor_value[r_ch];
    assign w_diff        = (w_mean >= w_sv_cur) ? ({1'b0, w_mean} - {1'b0, w_sv_cur})
                                                : ({1'b0, w_sv_cur} - {1'b0, w_mean});
    assign w_report      = (w_diff > {1'b0, Threshold_i});

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_state <= S_DISABLED;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cs_n         = '1;
        SPI_Write_o    = 1'b0;
        SPI_ReadNext_o = 1'b0;
        if (!Enable_i) begin
            w_state_next = S_DISABLED;
        end else begin
            case (r_state)
                S_DISABLED: w_state_next = S_IDLE;
                S_IDLE:     if (w_period_zero) w_state_next = S_WRITE;
                S_WRITE:    if (r_write_cnt) w_state_next = S_WAIT;
                S_WAIT:     if (!SPI_Transmission_i && !SPI_FIFOEmpty_i) w_state_next = S_READ1;
                S_READ1:    w_state_next = S_READ2;
                S_READ2:    w_state_next = w_last_sample ? S_EVAL : S_PAUSE;
                S_PAUSE:    if (r_pause_cnt <= 16'd1) w_state_next = S_WRITE;
                S_EVAL:     w_state_next = w_last_ch ? S_IDLE : S_WRITE;
                default:    w_state_next = S_DISABLED;
            endcase
        end
        case (r_state)
            S_WRITE: begin
                w_cs_n[r_ch] = 1'b0;
                SPI_Write_o  = 1'b1;
            end
            S_WAIT: begin
                w_cs_n[r_ch] = 1'b0;
            end
            S_READ1, S_READ2: begin
                w_cs_n[r_ch]   = 1'b0;
                SPI_ReadNext_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_period_cnt <= '0;
            r_pause_cnt  <= '0;
            r_write_cnt  <= 1'b0;
            r_sample_cnt <= '0;
            r_ch         <= '0;
            r_msb        <= '0;
            r_acc        <= '0;
            r_cpu_intr   <= 1'b0;
            for (int c = 0; c < Channels; c++) begin
                r_sensor_value[c] <= '0;
            end
        end else begin
            r_cpu_intr  <= 1'b0;
            r_write_cnt <= (r_state == S_WRITE) ? ~r_write_cnt : 1'b0;
            // Free-running during a round; an expiry outside Idle is simply lost.
            if (r_state == S_DISABLED || w_period_zero) begin
                r_period_cnt <= {PeriodCounterPresetH_i, PeriodCounterPresetL_i};
            end else begin
                r_period_cnt <= r_period_cnt - 32'd1;
            end
            case (r_state)
                S_DISABLED: begin
                    r_acc        <= '0;
                    r_sample_cnt <= '0;
                    r_ch         <= '0;
                end
                S_IDLE: begin
                    if (w_period_zero) begin
                        r_acc        <= '0;
                        r_sample_cnt <= '0;
                        r_ch         <= '0;
                    end
                end
                S_READ1: r_msb <= SPI_Data_i;
                S_READ2: begin
                    r_acc       <= r_acc + ACCW'({r_msb, SPI_Data_i});
                    r_pause_cnt <= PauseCounterPreset_i;
                    if (!w_last_sample) begin
                        r_sample_cnt <= r_sample_cnt + SCW'(1);
                    end
                end
                S_PAUSE: begin
                    if (r_pause_cnt != 16'd0) begin
                        r_pause_cnt <= r_pause_cnt - 16'd1;
                    end
                end
                S_EVAL: begin
                    if (w_report) begin
                        r_sensor_value[r_ch] <= w_mean;
                        r_cpu_intr           <= 1'b1;
                    end
                    r_acc        <= '0;
                    r_sample_cnt <= '0;
                    if (!w_last_ch) begin
                        r_ch <= r_ch + CHW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_SENSOR_MEAN_MC_IRQ_CHANNEL_EN
    logic [1:0] r_intr_ch;

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            r_intr_ch <= 2'd0;
        end else if (Enable_i && r_state == S_EVAL && w_report) begin
            r_intr_ch <= 2'(r_ch);
        end else if (!Enable_i && r_state == S_EVAL && w_report) begin
            r_intr_ch <= 2'(r_ch);
        end
    end

    assign IntrChannel_o = r_intr_ch;
`endif

    genvar g;
    generate
        for (g = 0; g < Channels; g++) begin : g_sv
            assign SensorValue_o[16*g +: 16] = r_sensor_value[g];
        end
    endgenerate

    assign CS_n_o     = w_cs_n;
    assign CpuIntr_o  = r_cpu_intr;
    assign SPI_Data_o = 8'h00;

endmodule
